quantum_gate_sequencer: RTL
===========================

Name: quantum_gate_sequencer

Overview:
Parametrised successor to the single-command gate controller. It buffers a queue of gate commands behind a valid/ready handshake and issues them one at a time to the gate/state datapath. Each gate is held for a programmable delay, followed by a one-cycle state-register update. It adds abort/flush, an executed-gate counter and a sequence-done indication, and sits between the user command interface and the quantum_gate / quantum_state pair.

Parameters:
AMP_W, 32, width of each amplitude word (alpha, beta)
GATE_W, 3, width of a gate code; code 0 is identity
QUEUE_DEPTH, 8, command FIFO entries (power of 2, >=2)
GATE_DELAY, 1000, EXECUTE cycles per gate (>=1)
CNT_W, 16, width of executed-gate counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
cmd_gate  in  GATE_W  gate code to enqueue
cmd_valid  in  1  command valid
cmd_ready  out  1  queue can accept (= not full)
abort  in  1  flush queue and cancel current gate
alpha_in  in  AMP_W  current alpha from state register
beta_in  in  AMP_W  current beta from state register
gate_sel  out  GATE_W  gate code driven to gate unit
gate_update_en  out  1  one-cycle state-register write enable
display_alpha  out  AMP_W  registered alpha_in snapshot
display_beta  out  AMP_W  registered beta_in snapshot
status  out  2  00 idle, 01 busy, 10 done
gate_busy  out  1  high whenever state != IDLE
queue_level  out  $clog2(QUEUE_DEPTH+1)  entries in queue
gate_count  out  CNT_W  gates executed since reset
seq_done  out  1  one-cycle pulse when the queue drains after an UPDATE
aborted  out  1  one-cycle pulse on abort acceptance

Behaviour:
- Reset (async, active-high) values: state IDLE, queue empty, cmd_ready=1, gate_sel=0, gate_update_en=0, display_*=0, status=00, gate_busy=0, queue_level=0, gate_count=0, seq_done=0, aborted=0.
- Enqueue when cmd_valid && cmd_ready && !abort:
  - cmd_gate==0 is accepted but discarded (not enqueued, not counted).
  - cmd_ready = !full; a push while full is not taken, even if a pop occurs in the same cycle.
- IDLE: if the queue is non-empty, go to LOAD the next cycle.
- LOAD (1 cycle): pop head, register gate_sel, clear timer, go to EXECUTE.
- EXECUTE: lasts exactly GATE_DELAY cycles, then go to UPDATE.
- UPDATE (1 cycle): gate_update_en=1 and gate_count+1 (wraps modulo 2^CNT_W).
  - Next state is LOAD if the queue is non-empty, else IDLE.
  - seq_done pulses in the cycle after UPDATE when the next state is IDLE.
- Latency: a handshake in cycle 0 into an idle, empty block gives LOAD in cycle 2 and gate_update_en in cycle GATE_DELAY+3. Back-to-back gate period is GATE_DELAY+2 cycles.
- gate_sel holds its value until the next LOAD; it is not cleared in IDLE.
- status: 01 in LOAD/EXECUTE/UPDATE; 10 for exactly the seq_done cycle; 00 otherwise.
- display_alpha/beta <= alpha_in/beta_in every cycle (1-cycle lag).
- abort (synchronous effect, highest priority):
  - Flushes the queue; any same-cycle push is dropped.
  - In LOAD/EXECUTE: go to IDLE, no update, gate_count unchanged.
  - In UPDATE: the update still completes, then go to IDLE.
  - aborted pulses the next cycle; seq_done is not asserted.
- queue_level reflects push/pop one cycle after the edge (registered).
- Reset mid-EXECUTE: immediate return to reset values; no gate_update_en is issued.

Decomposition:
- Package quantum_pkg: gate code constants (GATE_ID=0, …), status codes (ST_IDLE=2'b00, ST_BUSY=2'b01, ST_DONE=2'b10), FSM state enum {IDLE, LOAD, EXECUTE, UPDATE}.
- One sub-module, quantum_cmd_fifo: synchronous FIFO, parameters WIDTH=GATE_W and DEPTH=QUEUE_DEPTH, with push/pop/flush/full/empty/level.
- Timer and FSM stay in the top module.

Test Plan:
- GATE_DELAY=4, push gate 3 at cycle 0 -> LOAD at cycle 2, gate_update_en only at cycle 7, gate_sel=3, gate_count=1, seq_done at 8, status=10 at 8.
- Push 3 gates (1,2,5) back-to-back -> update_en at cycles 7, 13, 19; gate_sel sequence 1,2,5; single seq_done at 20; gate_count=3.
- QUEUE_DEPTH=4, hold cmd_valid for 6 gates while EXECUTE stalls -> cmd_ready low when queue_level=4 (LOAD pops first); the 6th is accepted only after the next pop; no command is lost or duplicated.
- Push gate 0 then gate 2 -> only gate 2 is executed; gate_count=1.
- Abort in mid-EXECUTE with 3 queued -> IDLE next cycle, queue_level=0, no gate_update_en, aborted pulse, gate_count unchanged.
- Assert reset during EXECUTE, and abort coincident with UPDATE -> reset: all outputs at reset values immediately; abort-in-UPDATE: update_en still high that cycle, then IDLE with queue empty.

Source files
------------

// File: rtl/quantum_pkg.sv
// Shared gate codes, status encodings and sequencer FSM states for the quantum gate sequencer.
package quantum_pkg;

    localparam int GATE_ID = 0;
    localparam int GATE_X  = 1;
    localparam int GATE_Y  = 2;
    localparam int GATE_Z  = 3;
    localparam int GATE_H  = 4;
    localparam int GATE_S  = 5;
    localparam int GATE_T  = 6;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        EXECUTE = 2'd2,
        UPDATE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/quantum_cmd_fifo.sv
// Gate command queue: push/pop take effect at the clock edge, level is registered.
// A push while full is refused even if a pop happens in the same cycle; flush wins over both.
module quantum_cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only read once the level says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/quantum_gate_sequencer.sv
// Queues gate commands and issues them one at a time: LOAD, GATE_DELAY EXECUTE cycles, one UPDATE.
// Handshake-to-LOAD is 2 cycles, gate period GATE_DELAY+2; cmd_ready drops only when the queue is full.
module quantum_gate_sequencer
    import quantum_pkg::*;
#(
    parameter int AMP_W       = 32,
    parameter int GATE_W      = 3,
    parameter int QUEUE_DEPTH = 8,
    parameter int GATE_DELAY  = 1000,
    parameter int CNT_W       = 16,
    localparam int QL_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GATE_W-1:0] cmd_gate,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              abort,
    input  logic [AMP_W-1:0]  alpha_in,
    input  logic [AMP_W-1:0]  beta_in,
    output logic [GATE_W-1:0] gate_sel,
    output logic              gate_update_en,
    output logic [AMP_W-1:0]  display_alpha,
    output logic [AMP_W-1:0]  display_beta,
    output logic [1:0]        status,
    output logic              gate_busy,
    output logic [QL_W-1:0]   queue_level,
    output logic [CNT_W-1:0]  gate_count,
    output logic              seq_done,
    output logic              aborted
);

    localparam int TMR_W = $clog2(GATE_DELAY + 1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [TMR_W-1:0]  timer;
    logic              fifo_full;
    logic              fifo_empty;
    logic [GATE_W-1:0] fifo_head;
    logic              push;
    logic              pop;

    assign cmd_ready = !fifo_full;
    // Identity gates are acknowledged but never occupy a queue slot.
    assign push      = cmd_valid && cmd_ready && !abort && (cmd_gate != GATE_W'(GATE_ID));

    quantum_cmd_fifo #(
        .WIDTH (GATE_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (cmd_gate),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .flush    (abort),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (queue_level)
    );

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !abort) next_state = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    pop        = 1'b1;
                    next_state = EXECUTE;
                end
            end
            EXECUTE: begin
                if (abort)                                next_state = IDLE;
                else if (timer == TMR_W'(GATE_DELAY - 1)) next_state = UPDATE;
            end
            UPDATE: begin
                next_state = (!fifo_empty && !abort) ? LOAD : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            gate_sel      <= '0;
            gate_count    <= '0;
            seq_done      <= 1'b0;
            aborted       <= 1'b0;
            display_alpha <= '0;
            display_beta  <= '0;
        end else begin
            state         <= next_state;
            display_alpha <= alpha_in;
            display_beta  <= beta_in;
            aborted       <= abort;
            seq_done      <= (state == UPDATE) && (next_state == IDLE) && !abort;
            timer         <= (state == EXECUTE) ? timer + 1'b1 : '0;
            if (pop)             gate_sel   <= fifo_head;
            // An UPDATE always completes, even when abort arrives in the same cycle.
            if (state == UPDATE) gate_count <= gate_count + 1'b1;
        end
    end

    assign gate_update_en = (state == UPDATE);
    assign gate_busy      = (state != IDLE);
    assign status         = gate_busy ? ST_BUSY : (seq_done ? ST_DONE : ST_IDLE);

endmodule
